// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse receive path: FSM states, element
// encoding, character limits and the dot-unit multipliers for the thresholds.
package morse_pkg;

    typedef enum logic [2:0] {
        WAIT_LOW,
        IDLE,
        MARK,
        GAP_ELEM,
        GAP_CHAR
    } state_t;

    localparam logic       ELEM_DOT      = 1'b0;
    localparam logic       ELEM_DASH     = 1'b1;
    localparam int         MAX_ELEMS     = 5;
    localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

    localparam int DASH_MULT = 2;
    localparam int CHAR_MULT = 2;
    localparam int WORD_MULT = 5;

endpackage

// File: rtl/morse_rx_decoder_if.sv
// Decoded-character output bundle of the Morse receiver. CHAR_VALID and
// WORD_GAP are single-cycle strobes with no back-pressure (no ready): a consumer
// must capture CHAR_* on the strobe cycle; CHAR_* then hold until the next strobe.
interface morse_rx_decoder_if;
    import morse_pkg::*;

    logic       CHAR_VALID;
    logic [4:0] CHAR_PAT;
    logic [2:0] CHAR_LEN;
    logic [7:0] CHAR_ASCII;
    logic       CHAR_ERR;
    logic       WORD_GAP;
    logic       KEY_ACTIVE;
    state_t     dbg_state;

    modport master (
        output CHAR_VALID, CHAR_PAT, CHAR_LEN, CHAR_ASCII, CHAR_ERR,
               WORD_GAP, KEY_ACTIVE, dbg_state
    );

    modport slave (
        input CHAR_VALID, CHAR_PAT, CHAR_LEN, CHAR_ASCII, CHAR_ERR,
              WORD_GAP, KEY_ACTIVE, dbg_state
    );

endinterface

// File: rtl/morse_lut.sv
// Combinational Morse lookup: (pattern, length) -> ASCII for A-Z and 0-9.
// Pattern holds the first element in bit0, 1 = dash; unused upper bits are 0.
module morse_lut
    import morse_pkg::*;
(
    input  logic [4:0] pat,
    input  logic [2:0] len,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = ASCII_UNKNOWN;
        case ({len, pat})
            {3'd2, 5'd2}:  ascii = 8'h41; // A
            {3'd4, 5'd1}:  ascii = 8'h42; // B
            {3'd4, 5'd5}:  ascii = 8'h43; // C
            {3'd3, 5'd1}:  ascii = 8'h44; // D
            {3'd1, 5'd0}:  ascii = 8'h45; // E
            {3'd4, 5'd4}:  ascii = 8'h46; // F
            {3'd3, 5'd3}:  ascii = 8'h47; // G
            {3'd4, 5'd0}:  ascii = 8'h48; // H
            {3'd2, 5'd0}:  ascii = 8'h49; // I
            {3'd4, 5'd14}: ascii = 8'h4A; // J
            {3'd3, 5'd5}:  ascii = 8'h4B; // K
            {3'd4, 5'd2}:  ascii = 8'h4C; // L
            {3'd2, 5'd3}:  ascii = 8'h4D; // M
            {3'd2, 5'd1}:  ascii = 8'h4E; // N
            {3'd3, 5'd7}:  ascii = 8'h4F; // O
            {3'd4, 5'd6}:  ascii = 8'h50; // P
            {3'd4, 5'd11}: ascii = 8'h51; // Q
            {3'd3, 5'd2}:  ascii = 8'h52; // R
            {3'd3, 5'd0}:  ascii = 8'h53; // S
            {3'd1, 5'd1}:  ascii = 8'h54; // T
            {3'd3, 5'd4}:  ascii = 8'h55; // U
            {3'd4, 5'd8}:  ascii = 8'h56; // V
            {3'd3, 5'd6}:  ascii = 8'h57; // W
            {3'd4, 5'd9}:  ascii = 8'h58; // X
            {3'd4, 5'd13}: ascii = 8'h59; // Y
            {3'd4, 5'd3}:  ascii = 8'h5A; // Z
            {3'd5, 5'd31}: ascii = 8'h30; // 0
            {3'd5, 5'd30}: ascii = 8'h31; // 1
            {3'd5, 5'd28}: ascii = 8'h32; // 2
            {3'd5, 5'd24}: ascii = 8'h33; // 3
            {3'd5, 5'd16}: ascii = 8'h34; // 4
            {3'd5, 5'd0}:  ascii = 8'h35; // 5
            {3'd5, 5'd1}:  ascii = 8'h36; // 6
            {3'd5, 5'd3}:  ascii = 8'h37; // 7
            {3'd5, 5'd7}:  ascii = 8'h38; // 8
            {3'd5, 5'd15}: ascii = 8'h39; // 9
            default:       ascii = ASCII_UNKNOWN;
        endcase
    end

endmodule

// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronises the key line, times marks/spaces against the dot
// unit, assembles elements into characters and flags character and word gaps.
module morse_rx_decoder
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES   = 25000000,
    parameter int GLITCH_CYCLES = 1000,
    parameter int CNT_W         = 28
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              KEY_IN,
    morse_rx_decoder_if.master rx
);

    localparam logic [CNT_W-1:0] GLITCH_TH = CNT_W'(GLITCH_CYCLES);
    localparam logic [CNT_W-1:0] DASH_TH   = CNT_W'(DASH_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_TH   = CNT_W'(CHAR_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] WORD_TH   = CNT_W'(WORD_MULT * UNIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [2:0]       MAX_LEN   = 3'(MAX_ELEMS);

    logic             key_m, key_s;
    logic [1:0]       fill;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [4:0]       pat, pat_n;
    logic [2:0]       len, len_n;
    logic             err, err_n;
    logic             emit_char, emit_word;
    logic             elem;
    logic [7:0]       lut_ascii;

    morse_lut u_lut (
        .pat   (pat),
        .len   (len),
        .ascii (lut_ascii)
    );

    assign cnt_inc       = (&cnt) ? cnt : cnt + CNT_ONE;
    assign elem          = (cnt >= DASH_TH) ? ELEM_DASH : ELEM_DOT;
    assign rx.KEY_ACTIVE = key_s;
    assign rx.dbg_state  = state;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pat_n     = pat;
        len_n     = len;
        err_n     = err;
        emit_char = 1'b0;
        emit_word = 1'b0;
        case (state)
            // key_s is only meaningful once both synchroniser flops hold real
            // samples; this keeps a key held through reset from being decoded.
            WAIT_LOW: if (fill[1] && !key_s) state_n = IDLE;
            IDLE: begin
                if (key_s) begin
                    state_n = MARK;
                    cnt_n   = CNT_ONE;
                end
            end
            MARK: begin
                if (key_s) begin
                    cnt_n = cnt_inc;
                end else if (cnt < GLITCH_TH) begin
                    state_n = (len != 3'd0) ? GAP_ELEM : IDLE;
                    cnt_n   = CNT_ONE;
                end else begin
                    if (len == MAX_LEN) begin
                        err_n = 1'b1;
                    end else begin
                        pat_n[len] = elem;
                        len_n      = len + 3'd1;
                    end
                    state_n = GAP_ELEM;
                    cnt_n   = CNT_ONE;
                end
            end
            GAP_ELEM: begin
                if (key_s) begin
                    state_n = MARK;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == CHAR_TH) begin
                        emit_char = 1'b1;
                        pat_n     = '0;
                        len_n     = '0;
                        err_n     = 1'b0;
                        state_n   = GAP_CHAR;
                    end
                end
            end
            GAP_CHAR: begin
                if (key_s) begin
                    state_n = MARK;
                    cnt_n   = CNT_ONE;
                end else begin
                    cnt_n = cnt_inc;
                    if (cnt_inc == WORD_TH) begin
                        emit_word = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = WAIT_LOW;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            key_m         <= 1'b0;
            key_s         <= 1'b0;
            fill          <= 2'd0;
            state         <= WAIT_LOW;
            cnt           <= '0;
            pat           <= '0;
            len           <= '0;
            err           <= 1'b0;
            rx.CHAR_VALID <= 1'b0;
            rx.WORD_GAP   <= 1'b0;
            rx.CHAR_PAT   <= '0;
            rx.CHAR_LEN   <= '0;
            rx.CHAR_ERR   <= 1'b0;
            rx.CHAR_ASCII <= 8'h00;
        end else begin
            key_m         <= KEY_IN;
            key_s         <= key_m;
            fill          <= fill[1] ? fill : fill + 2'd1;
            state         <= state_n;
            cnt           <= cnt_n;
            pat           <= pat_n;
            len           <= len_n;
            err           <= err_n;
            rx.CHAR_VALID <= emit_char;
            rx.WORD_GAP   <= emit_word;
            if (emit_char) begin
                rx.CHAR_PAT   <= pat;
                rx.CHAR_LEN   <= len;
                rx.CHAR_ERR   <= err;
                rx.CHAR_ASCII <= err ? ASCII_UNKNOWN : lut_ascii;
            end
        end
    end

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Directed bench for morse_rx_decoder with a dot unit of 10 cycles; decoded
// characters and word gaps are checked against an ordered expected queue.
module tb_morse_rx_decoder;
    import morse_pkg::*;

    localparam int W = 18;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic KEY_IN = 1'b0;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;

    morse_rx_decoder_if rx_if ();

    morse_rx_decoder #(
        .UNIT_CYCLES   (10),
        .GLITCH_CYCLES (3),
        .CNT_W         (28)
    ) dut (
        .CLK    (CLK),
        .RST    (RST),
        .KEY_IN (KEY_IN),
        .rx     (rx_if.master)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_char(input logic e, input logic [2:0] l,
                                             input logic [4:0] p, input logic [7:0] a);
        return {1'b0, e, l, p, a};
    endfunction

    function automatic logic [W-1:0] mk_word();
        return {1'b1, 17'd0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic lvl, input int n);
        KEY_IN = lvl;
        repeat (n) tick();
    endtask

    // Scoreboard: every strobe pops the next expected event in order.
    always @(negedge CLK) begin
        if (!RST) begin
            if (rx_if.CHAR_VALID && rx_if.WORD_GAP)
                check("strobe_overlap", 32'd1, 32'd0);
            if (rx_if.CHAR_VALID) begin
                if (exp_q.size() == 0) check("unexpected_char", 32'(rx_if.CHAR_ASCII), 32'hFFFF);
                else check("char", 32'({1'b0, rx_if.CHAR_ERR, rx_if.CHAR_LEN,
                                        rx_if.CHAR_PAT, rx_if.CHAR_ASCII}), 32'(exp_q.pop_front()));
            end
            if (rx_if.WORD_GAP) begin
                if (exp_q.size() == 0) check("unexpected_word_gap", 32'd1, 32'd0);
                else check("word_gap", 32'(mk_word()), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_state", 32'(rx_if.dbg_state), 32'(WAIT_LOW));
        check("rst_outputs", 32'({rx_if.CHAR_VALID, rx_if.WORD_GAP, rx_if.CHAR_ERR,
                                  rx_if.CHAR_LEN, rx_if.CHAR_PAT}), 32'd0);
        check("rst_ascii", 32'(rx_if.CHAR_ASCII), 32'h00);
        RST = 1'b0;
        repeat (5) tick();
        check("idle_after_rst", 32'(rx_if.dbg_state), 32'(IDLE));

        // 'A' with exact strobe timing
        exp_q.push_back(mk_char(1'b0, 3'd2, 5'b00010, 8'h41));
        exp_q.push_back(mk_word());
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 30);
        KEY_IN = 1'b0;
        for (int i = 1; i <= 52; i++) begin
            tick();
            if (i == 21) check("a_valid_early", 32'(rx_if.CHAR_VALID), 32'd0);
            if (i == 22) check("a_valid_at_20", 32'(rx_if.CHAR_VALID), 32'd1);
            if (i == 51) check("a_wg_early", 32'(rx_if.WORD_GAP), 32'd0);
            if (i == 52) check("a_wg_at_50", 32'(rx_if.WORD_GAP), 32'd1);
        end
        drive(1'b0, 5);
        check("a_idle", 32'(rx_if.dbg_state), 32'(IDLE));
        check("a_hold_ascii", 32'(rx_if.CHAR_ASCII), 32'h41);

        // Thresholds: 19 -> dot, 20 -> dash, 19-space continues
        exp_q.push_back(mk_char(1'b0, 3'd2, 5'b00010, 8'h41));
        exp_q.push_back(mk_word());
        drive(1'b1, 19); drive(1'b0, 19); drive(1'b1, 20); drive(1'b0, 60);
        // 20-space ends the character
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_word());
        drive(1'b1, 10); drive(1'b0, 20); drive(1'b1, 10); drive(1'b0, 60);

        // Glitch in idle is ignored
        drive(1'b1, 2); drive(1'b0, 10);
        check("glitch_idle", 32'(rx_if.dbg_state), 32'(IDLE));
        // Glitch inside an element gap is not an element
        exp_q.push_back(mk_char(1'b0, 3'd2, 5'b00010, 8'h41));
        exp_q.push_back(mk_word());
        drive(1'b1, 10); drive(1'b0, 10); drive(1'b1, 2); drive(1'b0, 10);
        drive(1'b1, 30); drive(1'b0, 60);

        // Overflow: six dots
        exp_q.push_back(mk_char(1'b1, 3'd5, 5'b00000, ASCII_UNKNOWN));
        exp_q.push_back(mk_word());
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 10); drive(1'b0, 10);
        end
        drive(1'b0, 50);

        // Word sequence "E E"
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_word());
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_word());
        drive(1'b1, 10); drive(1'b0, 50); drive(1'b1, 10); drive(1'b0, 55);
        // Mark at space 40 suppresses the word gap
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00000, 8'h45));
        exp_q.push_back(mk_word());
        drive(1'b1, 10); drive(1'b0, 40); drive(1'b1, 10); drive(1'b0, 60);
        check("queue_before_rst", 32'(exp_q.size()), 32'd0);

        // Reset mid-character, key held high across release
        drive(1'b1, 10); drive(1'b0, 5);
        KEY_IN = 1'b1;
        RST = 1'b1;
        repeat (3) tick();
        check("midchar_rst_ascii", 32'(rx_if.CHAR_ASCII), 32'h00);
        RST = 1'b0;
        drive(1'b1, 40);
        check("held_key_wait_low", 32'(rx_if.dbg_state), 32'(WAIT_LOW));
        check("key_active", 32'(rx_if.KEY_ACTIVE), 32'd1);
        drive(1'b0, 10);
        check("held_key_idle", 32'(rx_if.dbg_state), 32'(IDLE));
        exp_q.push_back(mk_char(1'b0, 3'd1, 5'b00001, 8'h54));
        exp_q.push_back(mk_word());
        drive(1'b1, 30); drive(1'b0, 60);

        drive(1'b0, 10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
